// File: rtl/params_mem_arbiter_pkg.sv
// Shared types for the parameter-memory arbiter.
// Memory geometry, burst length and FSM state encodings.
package params_mem_arbiter_pkg;
   localparam int CIM_PARAMS_NUM_WORD = 2048;
   localparam int CIM_PARAMS_BANK_SIZE_NUM_WORD = 1024;
   localparam int PARAM_ADDR_W = $clog2(CIM_PARAMS_NUM_WORD);
   localparam int PARAM_W = 16;
   localparam int PARAM_LEN_W = 10;

   typedef logic [PARAM_ADDR_W-1:0] ParamAddr_t;
   typedef logic [PARAM_W-1:0]      Param_t;
   typedef logic [PARAM_LEN_W-1:0]  ParamBurstLen_t;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } ParamArbState_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/params_mem_arbiter_if.sv
// Requester-side and memory-side bus of the parameter arbiter.
// slave = arbiter view, master = requesters/memory view.
interface params_mem_arbiter_if #(
   parameter int NUM_RD = 2,
   parameter int LEN_W = 10
);
   import params_mem_arbiter_pkg::*;

   logic [NUM_RD-1:0]            rd_req;
   ParamAddr_t [NUM_RD-1:0]      rd_base_addr;
   logic [NUM_RD-1:0][LEN_W-1:0] rd_len;
   logic [NUM_RD-1:0]            rd_grant;
   logic [NUM_RD-1:0]            rd_valid;
   logic [NUM_RD-1:0]            rd_done;
   Param_t                       rd_data;
   logic                         wr_req;
   ParamAddr_t                   wr_addr;
   Param_t                       wr_data;
   logic                         wr_ack;
   logic                         mem_rd_en;
   ParamAddr_t                   mem_rd_addr;
   Param_t                       mem_rd_data;
   logic                         mem_wr_en;
   ParamAddr_t                   mem_wr_addr;
   Param_t                       mem_wr_data;
   logic                         mem_chip_en;

   modport slave (
      input  rd_req, rd_base_addr, rd_len,
      input  wr_req, wr_addr, wr_data, mem_rd_data,
      output rd_grant, rd_valid, rd_done, rd_data,
      output wr_ack, mem_rd_en, mem_rd_addr,
      output mem_wr_en, mem_wr_addr, mem_wr_data,
      output mem_chip_en
   );

   modport master (
      output rd_req, rd_base_addr, rd_len,
      output wr_req, wr_addr, wr_data, mem_rd_data,
      input  rd_grant, rd_valid, rd_done, rd_data,
      input  wr_ack, mem_rd_en, mem_rd_addr,
      input  mem_wr_en, mem_wr_addr, mem_wr_data,
      input  mem_chip_en
   );
endinterface

// File: rtl/params_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after i_ptr.
// The pointer itself lives in the caller.
module rr_arbiter #(
   parameter int N = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_idx
);
   always_comb begin
      int j;
      o_gnt = '0;
      o_idx = '0;
      j = 0;
      // farthest first, so the nearest requester overwrites
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(i_ptr) + k;
         if (j >= N) j = j - N;
         if (i_req[IDX_W'(j)]) begin
            o_gnt = '0;
            o_gnt[IDX_W'(j)] = 1'b1;
            o_idx = IDX_W'(j);
         end
      end
   end
endmodule

// File: rtl/params_mem_arbiter.sv
// Shares the parameter memory between burst readers and one writer.
// Writes win in IDLE; bursts run to completion once granted.
module params_mem_arbiter
   import params_mem_arbiter_pkg::*;
#(
   parameter int NUM_RD = 2,
   parameter int LEN_W = 10
) (
   input logic                 clk,
   input logic                 rst_n,
   params_mem_arbiter_if.slave bus
);
   localparam int IDX_W = idx_w(NUM_RD);
   typedef logic [LEN_W-1:0] len_t;

   ParamArbState_t    r_state, w_state_nx;
   logic [IDX_W-1:0]  r_rr, r_owner, r_ret_owner;
   logic [IDX_W-1:0]  w_arb_idx, w_rr_nx;
   ParamAddr_t        r_base, w_rd_addr;
   len_t              r_len, r_cnt;
   logic              r_ret_vld, r_ret_last, r_chip_en;
   logic [NUM_RD-1:0] w_arb_gnt, w_grant;
   logic [NUM_RD-1:0] w_valid, w_done;
   logic              w_wr_ack, w_rd_en, w_last;

   rr_arbiter #(
      .N     (NUM_RD),
      .IDX_W (IDX_W)
   ) u_rr (
      .i_req (bus.rd_req),
      .i_ptr (r_rr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx)
   );

   assign w_rr_nx = (int'(w_arb_idx) == NUM_RD - 1) ?
                    '0 : w_arb_idx + IDX_W'(1);

   // IDLE outputs are gated by rst_n so reset forces them low at once
   always_comb begin
      w_state_nx = r_state;
      w_grant    = '0;
      w_wr_ack   = 1'b0;
      w_rd_en    = 1'b0;
      w_rd_addr  = '0;
      w_last     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (rst_n && bus.wr_req) begin
               w_wr_ack = 1'b1;
            end else if (rst_n && (|bus.rd_req)) begin
               w_grant    = w_arb_gnt;
               w_state_nx = BURST;
            end
         end
         BURST: begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_base + ParamAddr_t'(r_cnt);
            w_last    = (r_cnt == r_len - len_t'(1));
            if (w_last) w_state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rr        <= '0;
         r_owner     <= '0;
         r_base      <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_ret_vld   <= 1'b0;
         r_ret_owner <= '0;
         r_ret_last  <= 1'b0;
         r_chip_en   <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_chip_en   <= 1'b1;
         r_ret_vld   <= w_rd_en;
         r_ret_owner <= r_owner;
         r_ret_last  <= w_last;
         if (|w_grant) begin
            r_owner <= w_arb_idx;
            r_base  <= bus.rd_base_addr[w_arb_idx];
            r_len   <= bus.rd_len[w_arb_idx];
            r_cnt   <= '0;
            r_rr    <= w_rr_nx;
         end else if (w_rd_en) begin
            r_cnt <= r_cnt + len_t'(1);
         end
      end
   end

   always_comb begin
      w_valid = '0;
      w_done  = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         w_valid[i] = r_ret_vld && (r_ret_owner == IDX_W'(i));
         w_done[i]  = w_valid[i] && r_ret_last;
      end
   end

   assign bus.rd_grant    = w_grant;
   assign bus.rd_valid    = w_valid;
   assign bus.rd_done     = w_done;
   assign bus.rd_data     = bus.mem_rd_data;
   assign bus.wr_ack      = w_wr_ack;
   assign bus.mem_rd_en   = w_rd_en;
   assign bus.mem_rd_addr = w_rd_addr;
   assign bus.mem_wr_en   = w_wr_ack;
   assign bus.mem_wr_addr = w_wr_ack ? bus.wr_addr : '0;
   assign bus.mem_wr_data = w_wr_ack ? bus.wr_data : '0;
   assign bus.mem_chip_en = r_chip_en;

   a_len_nz : assert property (@(posedge clk) disable iff (!rst_n)
      (|w_grant) |-> (bus.rd_len[w_arb_idx] != '0));

   a_no_wrap : assert property (@(posedge clk) disable iff (!rst_n)
      (|w_grant) |-> (int'(bus.rd_base_addr[w_arb_idx]) +
                      int'(bus.rd_len[w_arb_idx]) <= CIM_PARAMS_NUM_WORD));

   a_one_valid : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(w_valid));

   a_rw_clash : assert property (@(posedge clk) disable iff (!rst_n)
      !(w_rd_en && w_wr_ack && (w_rd_addr == bus.wr_addr)));

   for (genvar g = 0; g < NUM_RD; g++) begin : g_hold
      a_req_hold : assert property (@(posedge clk) disable iff (!rst_n)
         (bus.rd_req[g] && !w_grant[g]) |=> bus.rd_req[g]);
   end
endmodule

// File: tb/tb_params_mem_arbiter.sv
// Directed bench for params_mem_arbiter: vector table plus
// hand sequences for write-during-burst, bank crossing and reset.
module tb_params_mem_arbiter;
   import params_mem_arbiter_pkg::*;

   typedef struct {
      logic [1:0] req;
      ParamAddr_t b0;
      logic [9:0] l0;
      ParamAddr_t b1;
      logic [9:0] l1;
      logic       wr;
      ParamAddr_t wa;
      Param_t     wd;
      logic [1:0] g;
      logic       ack;
      logic       ren;
      ParamAddr_t ra;
      logic [1:0] v;
      logic [1:0] d;
      Param_t     dat;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   vec_t tbl[$];
   Param_t wmem[int];

   params_mem_arbiter_if #(.NUM_RD(2), .LEN_W(10)) bus();

   params_mem_arbiter #(.NUM_RD(2), .LEN_W(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic Param_t pv(input ParamAddr_t a);
      return {5'h15, a};
   endfunction

   // memory model: preload pattern overlaid with whatever was written
   always @(posedge clk) begin
      if (bus.mem_wr_en) wmem[int'(bus.mem_wr_addr)] = bus.mem_wr_data;
      if (bus.mem_rd_en)
         bus.mem_rd_data <= wmem.exists(int'(bus.mem_rd_addr)) ?
                            wmem[int'(bus.mem_rd_addr)] : pv(bus.mem_rd_addr);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(
      input logic [1:0] req, input ParamAddr_t b0, input logic [9:0] l0,
      input ParamAddr_t b1, input logic [9:0] l1, input logic wr,
      input ParamAddr_t wa, input Param_t wd, input logic [1:0] g,
      input logic ack, input logic ren, input ParamAddr_t ra,
      input logic [1:0] v, input logic [1:0] d, input Param_t dat);
      vec_t t;
      t.req = req; t.b0 = b0; t.l0 = l0; t.b1 = b1; t.l1 = l1;
      t.wr = wr; t.wa = wa; t.wd = wd; t.g = g; t.ack = ack;
      t.ren = ren; t.ra = ra; t.v = v; t.d = d; t.dat = dat;
      return t;
   endfunction

   task automatic drive(input vec_t t);
      bus.rd_req          = t.req;
      bus.rd_base_addr[0] = t.b0;
      bus.rd_len[0]       = t.l0;
      bus.rd_base_addr[1] = t.b1;
      bus.rd_len[1]       = t.l1;
      bus.wr_req          = t.wr;
      bus.wr_addr         = t.wa;
      bus.wr_data         = t.wd;
   endtask

   task automatic set_rd(input logic [1:0] req, input ParamAddr_t b0,
                         input logic [9:0] l0, input ParamAddr_t b1,
                         input logic [9:0] l1);
      bus.rd_req          = req;
      bus.rd_base_addr[0] = b0;
      bus.rd_len[0]       = l0;
      bus.rd_base_addr[1] = b1;
      bus.rd_len[1]       = l1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      set_rd(2'b01, 11'h010, 10'd4, 11'h0, 10'd1);
      bus.wr_req  = 1'b1;
      bus.wr_addr = 11'h055;
      bus.wr_data = 16'h7777;
      #3;
      chk("rst.grant", bus.rd_grant, 0);
      chk("rst.ack", bus.wr_ack, 0);
      chk("rst.wr_en", bus.mem_wr_en, 0);
      chk("rst.wr_addr", bus.mem_wr_addr, 0);
      chk("rst.rd_en", bus.mem_rd_en, 0);
      chk("rst.valid", bus.rd_valid, 0);
      chk("rst.done", bus.rd_done, 0);
      chk("rst.chip_en", bus.mem_chip_en, 0);
      set_rd(2'b00, 11'h0, 10'd1, 11'h0, 10'd1);
      bus.wr_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // plain 4-beat burst from requester 0
      tbl.push_back(mk(2'b01, 11'h010, 4, 0, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 11'h010, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 11'h011, 2'b01, 0, pv(11'h010)));
      tbl.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 11'h012, 2'b01, 0, pv(11'h011)));
      tbl.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 11'h013, 2'b01, 0, pv(11'h012)));
      tbl.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, pv(11'h013)));
      tbl.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // write beats a simultaneous read, then read it back
      tbl.push_back(mk(2'b10, 0, 1, 11'h200, 1, 1, 11'h200, 16'h1234, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2'b10, 0, 1, 11'h200, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 11'h200, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 16'h1234));
      // two requesters held: 0, 1, 0, 1 rotation
      tbl.push_back(mk(2'b11, 11'h040, 2, 11'h080, 2, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2'b11, 11'h040, 2, 11'h080, 2, 0, 0, 0, 0, 0, 1, 11'h040, 0, 0, 0));
      tbl.push_back(mk(2'b11, 11'h040, 2, 11'h080, 2, 0, 0, 0, 0, 0, 1, 11'h041, 2'b01, 0, pv(11'h040)));
      tbl.push_back(mk(2'b11, 11'h040, 2, 11'h080, 2, 0, 0, 0, 2'b10, 0, 0, 0, 2'b01, 2'b01, pv(11'h041)));
      tbl.push_back(mk(2'b11, 11'h040, 2, 11'h080, 2, 0, 0, 0, 0, 0, 1, 11'h080, 0, 0, 0));
      tbl.push_back(mk(2'b11, 11'h040, 2, 11'h080, 2, 0, 0, 0, 0, 0, 1, 11'h081, 2'b10, 0, pv(11'h080)));
      tbl.push_back(mk(2'b11, 11'h040, 2, 11'h080, 2, 0, 0, 0, 2'b01, 0, 0, 0, 2'b10, 2'b10, pv(11'h081)));
      tbl.push_back(mk(2'b10, 11'h040, 2, 11'h080, 2, 0, 0, 0, 0, 0, 1, 11'h040, 0, 0, 0));
      tbl.push_back(mk(2'b10, 11'h040, 2, 11'h080, 2, 0, 0, 0, 0, 0, 1, 11'h041, 2'b01, 0, pv(11'h040)));
      tbl.push_back(mk(2'b10, 11'h040, 2, 11'h080, 2, 0, 0, 0, 2'b10, 0, 0, 0, 2'b01, 2'b01, pv(11'h041)));
      tbl.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 11'h080, 0, 0, 0));
      tbl.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 11'h081, 2'b10, 0, pv(11'h080)));
      tbl.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, pv(11'h081)));
      tbl.push_back(mk(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         step();
         drive(tbl[i]);
         @(negedge clk);
         chk($sformatf("v%0d.grant", i), bus.rd_grant, tbl[i].g);
         chk($sformatf("v%0d.ack", i), bus.wr_ack, tbl[i].ack);
         chk($sformatf("v%0d.wr_en", i), bus.mem_wr_en, tbl[i].ack);
         chk($sformatf("v%0d.rd_en", i), bus.mem_rd_en, tbl[i].ren);
         chk($sformatf("v%0d.rd_addr", i), bus.mem_rd_addr, tbl[i].ra);
         chk($sformatf("v%0d.valid", i), bus.rd_valid, tbl[i].v);
         chk($sformatf("v%0d.done", i), bus.rd_done, tbl[i].d);
         chk($sformatf("v%0d.chip_en", i), bus.mem_chip_en, 1);
         if (tbl[i].ack) begin
            chk($sformatf("v%0d.wr_addr", i), bus.mem_wr_addr, tbl[i].wa);
            chk($sformatf("v%0d.wr_data", i), bus.mem_wr_data, tbl[i].wd);
         end
         if (tbl[i].v != 2'b00)
            chk($sformatf("v%0d.data", i), bus.rd_data, tbl[i].dat);
      end

      // write raised mid-burst waits for IDLE, lands beside the last beat
      step();
      set_rd(2'b01, 11'h100, 10'd8, 11'h0, 10'd1);
      @(negedge clk);
      chk("wb.grant", bus.rd_grant, 2'b01);
      for (int k = 1; k <= 9; k++) begin
         step();
         if (k == 1) bus.rd_req = 2'b00;
         if (k == 3) begin
            bus.wr_req  = 1'b1;
            bus.wr_addr = 11'h300;
            bus.wr_data = 16'hBEEF;
         end
         @(negedge clk);
         chk($sformatf("wb%0d.rd_en", k), bus.mem_rd_en, k <= 8);
         if (k <= 8)
            chk($sformatf("wb%0d.addr", k), bus.mem_rd_addr, 11'h100 + k - 1);
         chk($sformatf("wb%0d.ack", k), bus.wr_ack, k == 9);
         chk($sformatf("wb%0d.valid", k), bus.rd_valid, (k >= 2) ? 2'b01 : 2'b00);
         chk($sformatf("wb%0d.done", k), bus.rd_done, (k == 9) ? 2'b01 : 2'b00);
         if (k >= 2)
            chk($sformatf("wb%0d.data", k), bus.rd_data, pv(ParamAddr_t'(11'h100 + k - 2)));
      end
      chk("wb.wr_addr", bus.mem_wr_addr, 11'h300);
      chk("wb.wr_data", bus.mem_wr_data, 16'hBEEF);

      // burst straddling the bank boundary, requester 1
      step();
      bus.wr_req = 1'b0;
      set_rd(2'b10, 11'h0, 10'd1, ParamAddr_t'(CIM_PARAMS_BANK_SIZE_NUM_WORD - 2), 10'd4);
      @(negedge clk);
      chk("bk.grant", bus.rd_grant, 2'b10);
      for (int k = 1; k <= 5; k++) begin
         step();
         bus.rd_req = 2'b00;
         @(negedge clk);
         chk($sformatf("bk%0d.rd_en", k), bus.mem_rd_en, k <= 4);
         if (k <= 4)
            chk($sformatf("bk%0d.addr", k), bus.mem_rd_addr, 11'h3FE + k - 1);
         chk($sformatf("bk%0d.valid", k), bus.rd_valid, (k >= 2) ? 2'b10 : 2'b00);
         chk($sformatf("bk%0d.done", k), bus.rd_done, (k == 5) ? 2'b10 : 2'b00);
         if (k >= 2)
            chk($sformatf("bk%0d.data", k), bus.rd_data, pv(ParamAddr_t'(11'h3FE + k - 2)));
      end

      // reset during beat 3 of a 6-beat burst
      step();
      set_rd(2'b01, 11'h020, 10'd6, 11'h0, 10'd1);
      @(negedge clk);
      chk("rb.grant", bus.rd_grant, 2'b01);
      step();
      bus.rd_req = 2'b00;
      @(negedge clk);
      chk("rb.addr1", bus.mem_rd_addr, 11'h020);
      step();
      @(negedge clk);
      chk("rb.valid2", bus.rd_valid, 2'b01);
      step();
      #1;
      rst_n = 1'b0;
      #1;
      chk("rb.rst.valid", bus.rd_valid, 0);
      chk("rb.rst.done", bus.rd_done, 0);
      chk("rb.rst.rd_en", bus.mem_rd_en, 0);
      chk("rb.rst.rd_addr", bus.mem_rd_addr, 0);
      chk("rb.rst.chip_en", bus.mem_chip_en, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("rb.post%0d.valid", k), bus.rd_valid, 0);
         chk($sformatf("rb.post%0d.done", k), bus.rd_done, 0);
         chk($sformatf("rb.post%0d.rd_en", k), bus.mem_rd_en, 0);
      end
      step();
      set_rd(2'b11, 11'h030, 10'd1, 11'h031, 10'd1);
      @(negedge clk);
      chk("rb.new.grant0", bus.rd_grant, 2'b01);
      step();
      bus.rd_req = 2'b10;
      @(negedge clk);
      chk("rb.new.addr0", bus.mem_rd_addr, 11'h030);
      step();
      @(negedge clk);
      chk("rb.new.grant1", bus.rd_grant, 2'b10);
      chk("rb.new.done0", bus.rd_done, 2'b01);
      chk("rb.new.data0", bus.rd_data, pv(11'h030));
      step();
      bus.rd_req = 2'b00;
      @(negedge clk);
      chk("rb.new.addr1", bus.mem_rd_addr, 11'h031);
      step();
      @(negedge clk);
      chk("rb.new.done1", bus.rd_done, 2'b10);
      chk("rb.new.data1", bus.rd_data, pv(11'h031));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
